// File: rtl/dmem_lane_ctrl_if.sv
// Request/response bus of the MEM-stage data memory, with its pipeline controls.
// Handshake: there is no ready. A request is taken on a rising edge when
// req_valid & en & ~flush and the block is not in reset. Every taken request
// returns exactly one rsp_valid beat, in order, RD_LAT enabled edges later.
// A response stays on the outputs while en is low.
interface dmem_lane_ctrl_if #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 32
);
    logic               en;
    logic               flush;
    logic               req_valid;
    logic               req_we;
    logic [ADDR_W-1:0]  req_addr;
    logic [1:0]         req_size;
    logic               req_unsigned;
    logic [8*LANES-1:0] req_wdata;
    logic               rsp_valid;
    logic               rsp_we;
    logic [8*LANES-1:0] rsp_rdata;
    logic               rsp_err;

    modport master (
        output en, flush, req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  rsp_valid, rsp_we, rsp_rdata, rsp_err
    );

    modport slave (
        input  en, flush, req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output rsp_valid, rsp_we, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane data memory for the MEM stage. It has LANES little-endian byte
// arrays, an internal byte-enable decode, and load sign or zero extension.
// Misaligned, oversized and out-of-range accesses return an error response
// and never write. The read pipeline is 1 or 2 enabled cycles deep. The
// memory arrays have no reset. Their zero power-up contents come from how the
// target initialises its RAM.
module dmem_lane_ctrl #(
    parameter int LANES  = 4,
    parameter int DEPTH  = 7168,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_lane_ctrl_if.slave bus
);
    localparam int DATA_W = 8 * LANES;
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Attributes that travel alongside the read data; the debug view of a stage.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic              err;
        logic [LANE_W-1:0] off;
        logic [1:0]        size;
        logic              uns;
    } stage_t;

    logic [LANE_W-1:0] req_off;
    logic [ADDR_W-1:0] word_full;
    logic [IDX_W-1:0]  req_idx;
    logic [LANE_W-1:0] align_mask;
    logic              oversized;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic [LANES-1:0]  byte_en;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rd_word;

    // Decode the incoming request: word index, lane offset, error checks, byte enables.
    always_comb begin
        req_off    = bus.req_addr[LANE_W-1:0];
        word_full  = bus.req_addr >> LANE_W;
        req_idx    = word_full[IDX_W-1:0];
        align_mask = '0;
        for (int i = 0; i < LANE_W; i++) begin
            align_mask[i] = (i < int'(bus.req_size));
        end
        oversized    = int'(bus.req_size) > LANE_W;
        misaligned   = |(req_off & align_mask);
        out_of_range = word_full >= ADDR_W'(DEPTH);
        req_err      = oversized | misaligned | out_of_range;
        accept       = bus.req_valid & bus.en & ~bus.flush & ~rst;
        wr_en        = accept & bus.req_we & ~req_err;
        // The read port follows en so the read data register holds during a stall.
        rd_en        = bus.en & ~out_of_range;
        // Store data is right-aligned. Move byte 0 up to the lane at the offset.
        wdata_sh     = bus.req_wdata << {req_off, 3'b000};
        byte_en      = '0;
        for (int k = 0; k < LANES; k++) begin
            byte_en[k] = (k >= int'(req_off)) &&
                         (k < int'(req_off) + (1 << int'(bus.req_size)));
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_byte;

        // One byte lane: a masked write port and a registered read port.
        always_ff @(posedge clk) begin
            if (wr_en && byte_en[k]) begin
                lane_mem[req_idx] <= wdata_sh[8*k +: 8];
            end
            if (rd_en) begin
                rd_byte <= lane_mem[req_idx];
            end
        end

        assign rd_word[8*k +: 8] = rd_byte;
    end

    stage_t s1_q;

    // First stage: capture request attributes in step with the memory read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
        end else if (bus.flush) begin
            s1_q.valid <= 1'b0;
        end else if (bus.en) begin
            s1_q.valid <= bus.req_valid;
            s1_q.we    <= bus.req_we;
            s1_q.err   <= req_err;
            s1_q.off   <= req_off;
            s1_q.size  <= bus.req_size;
            s1_q.uns   <= bus.req_unsigned;
        end
    end

    stage_t            out_q;
    logic [DATA_W-1:0] out_raw;

    if (RD_LAT >= 2) begin : g_lat2
        stage_t            s2_q;
        logic [DATA_W-1:0] raw2_q;

        // Second stage: attributes advance one more enabled edge; flush kills the beat.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_q <= '0;
            end else if (bus.flush) begin
                s2_q.valid <= 1'b0;
            end else if (bus.en) begin
                s2_q <= s1_q;
            end
        end

        // Raw lane data is registered once more before extension.
        always_ff @(posedge clk) begin
            if (bus.en) begin
                raw2_q <= rd_word;
            end
        end

        assign out_q   = s2_q;
        assign out_raw = raw2_q;
    end else begin : g_lat1
        assign out_q   = s1_q;
        assign out_raw = rd_word;
    end

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] extended;
    logic              sign;

    // Align the selected bytes to bit 0, then sign- or zero-extend them. Full-word loads pass through unchanged.
    always_comb begin
        shifted  = out_raw >> {out_q.off, 3'b000};
        extended = shifted;
        sign     = 1'b0;
        for (int s = 0; s < LANE_W; s++) begin
            if (int'(out_q.size) == s) begin
                sign = shifted[(8 << s) - 1] & ~out_q.uns;
            end
        end
        for (int b = 0; b < DATA_W; b++) begin
            if ((int'(out_q.size) < LANE_W) && (b >= (8 << int'(out_q.size)))) begin
                extended[b] = sign;
            end
        end
    end

    // All response fields come from registers and read zero when no beat is valid.
    assign bus.rsp_valid = out_q.valid;
    assign bus.rsp_we    = out_q.valid & out_q.we;
    assign bus.rsp_err   = out_q.valid & out_q.err;
    assign bus.rsp_rdata = (out_q.valid & ~out_q.we & ~out_q.err) ? extended : '0;

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Bench for dmem_lane_ctrl. Two instances receive the same stimulus:
// dut1 has RD_LAT=1 and dut2 has RD_LAT=2. The reference model is a flat byte
// array plus one delay line of expected responses per instance.
module tb_dmem_lane_ctrl;
    localparam int LANES  = 4;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int W      = 35;  // {valid, we, err, rdata[31:0]}

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en, flush, req_valid, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    dmem_lane_ctrl_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus1 ();
    dmem_lane_ctrl_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus2 ();

    assign bus1.en = en;             assign bus2.en = en;
    assign bus1.flush = flush;       assign bus2.flush = flush;
    assign bus1.req_valid = req_valid;       assign bus2.req_valid = req_valid;
    assign bus1.req_we = req_we;             assign bus2.req_we = req_we;
    assign bus1.req_addr = req_addr;         assign bus2.req_addr = req_addr;
    assign bus1.req_size = req_size;         assign bus2.req_size = req_size;
    assign bus1.req_unsigned = req_unsigned; assign bus2.req_unsigned = req_unsigned;
    assign bus1.req_wdata = req_wdata;       assign bus2.req_wdata = req_wdata;

    dmem_lane_ctrl #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    dmem_lane_ctrl #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // reference model and scoreboard
    logic [7:0]   mem_m [DEPTH*LANES];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [W-1:0] rsp(input logic v, input logic we, input logic err,
                                         input logic [31:0] d);
        return {v, we, err, d};
    endfunction

    function automatic logic [W-1:0] obs1();
        return {bus1.rsp_valid, bus1.rsp_we, bus1.rsp_err, bus1.rsp_rdata};
    endfunction

    function automatic logic [W-1:0] obs2();
        return {bus2.rsp_valid, bus2.rsp_we, bus2.rsp_err, bus2.rsp_rdata};
    endfunction

    // Expected response for the request on the inputs, from the memory as it is now.
    function automatic logic [W-1:0] model_entry();
        int          nb;
        int          off;
        logic [31:0] word;
        logic [63:0] val;
        logic        err;
        if (!req_valid) return '0;
        nb   = 1 << req_size;
        off  = int'(req_addr[1:0]);
        word = req_addr >> 2;
        err  = (nb > LANES) || ((off % nb) != 0) || (word >= 32'(DEPTH));
        if (err) return rsp(1'b1, req_we, 1'b1, 32'h0);
        if (req_we) return rsp(1'b1, 1'b1, 1'b0, 32'h0);
        val = '0;
        for (int b = 0; b < nb; b++) val |= 64'(mem_m[int'(req_addr) + b]) << (8 * b);
        if (!req_unsigned && nb < LANES && val[8*nb-1]) val |= ~((64'd1 << (8 * nb)) - 64'd1);
        return rsp(1'b1, 1'b0, 1'b0, val[31:0]);
    endfunction

    // Advance one clock: update the model from the current inputs, then sample #1 after the edge.
    task automatic step();
        logic [W-1:0] e;
        e = model_entry();
        if (rst || flush) begin
            foreach (exp_q1[i]) exp_q1[i] = '0;
            foreach (exp_q2[i]) exp_q2[i] = '0;
        end else if (en) begin
            if (e[34] && e[33] && !e[32]) begin
                for (int b = 0; b < (1 << req_size); b++)
                    mem_m[int'(req_addr) + b] = req_wdata[8*b +: 8];
            end
            exp_q1.push_front(e); void'(exp_q1.pop_back());
            exp_q2.push_front(e); void'(exp_q2.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic idle();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_size = size; req_unsigned = uns; req_wdata = wd;
        step();
        idle();
    endtask

    task automatic wait_cycles(input int n);
        idle();
        repeat (n) step();
    endtask

    task automatic init_mem();
        for (int i = 0; i < DEPTH * LANES; i++) mem_m[i] = 8'h00;
        for (int w = 0; w < DEPTH; w++) issue(1'b1, 32'(w * 4), 2'd2, 1'b0, 32'h0);
        wait_cycles(2);
    endtask

    task automatic test_reset();
        exp_q1 = {}; exp_q1.push_back('0);
        exp_q2 = {}; exp_q2.push_back('0); exp_q2.push_back('0);
        en = 1'b1; flush = 1'b0; rst = 1'b1;
        idle();
        step(); step();
        checks++; if (obs1() !== '0) begin errors++; $display("FAIL reset_dut1 got %h want 0", obs1()); end
        checks++; if (obs2() !== '0) begin errors++; $display("FAIL reset_dut2 got %h want 0", obs2()); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        issue(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        checks++; if (obs1() !== rsp(1, 1, 0, 0)) begin errors++; $display("FAIL store_rsp got %h want %h", obs1(), rsp(1, 1, 0, 0)); end
        issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'hDEADBEEF)) begin errors++; $display("FAIL word_load got %h want %h", obs1(), rsp(1, 0, 0, 32'hDEADBEEF)); end
        checks++; if (obs2() !== rsp(1, 1, 0, 0)) begin errors++; $display("FAIL store_rsp_lat2 got %h want %h", obs2(), rsp(1, 1, 0, 0)); end
        wait_cycles(1);
        checks++; if (obs2() !== rsp(1, 0, 0, 32'hDEADBEEF)) begin errors++; $display("FAIL word_load_lat2 got %h want %h", obs2(), rsp(1, 0, 0, 32'hDEADBEEF)); end
        checks++; if (obs1() !== '0) begin errors++; $display("FAIL idle_after_load got %h want 0", obs1()); end
    endtask

    task automatic test_byte_ext();
        issue(1'b1, 32'h21, 2'd0, 1'b0, 32'h80);
        issue(1'b0, 32'h21, 2'd0, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'hFFFFFF80)) begin errors++; $display("FAIL byte_signed got %h want %h", obs1(), rsp(1, 0, 0, 32'hFFFFFF80)); end
        issue(1'b0, 32'h21, 2'd0, 1'b1, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'h00000080)) begin errors++; $display("FAIL byte_unsigned got %h want %h", obs1(), rsp(1, 0, 0, 32'h80)); end
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'h00008000)) begin errors++; $display("FAIL byte_in_word got %h want %h", obs1(), rsp(1, 0, 0, 32'h8000)); end
        issue(1'b0, 32'h20, 2'd1, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'hFFFF8000)) begin errors++; $display("FAIL half_signed got %h want %h", obs1(), rsp(1, 0, 0, 32'hFFFF8000)); end
        issue(1'b1, 32'h26, 2'd1, 1'b0, 32'h5555ABCD);
        issue(1'b0, 32'h24, 2'd2, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'hABCD0000)) begin errors++; $display("FAIL half_store_lanes got %h want %h", obs1(), rsp(1, 0, 0, 32'hABCD0000)); end
        issue(1'b0, 32'h27, 2'd0, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'hFFFFFFAB)) begin errors++; $display("FAIL byte_lane3_signed got %h want %h", obs1(), rsp(1, 0, 0, 32'hFFFFFFAB)); end
        issue(1'b0, 32'h26, 2'd1, 1'b1, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'h0000ABCD)) begin errors++; $display("FAIL half_unsigned got %h want %h", obs1(), rsp(1, 0, 0, 32'hABCD)); end
    endtask

    task automatic test_errors();
        issue(1'b0, 32'h13, 2'd1, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 1, 0)) begin errors++; $display("FAIL misaligned_half got %h want %h", obs1(), rsp(1, 0, 1, 0)); end
        issue(1'b1, 32'h22, 2'd2, 1'b0, 32'hFFFFFFFF);
        checks++; if (obs1() !== rsp(1, 1, 1, 0)) begin errors++; $display("FAIL misaligned_store got %h want %h", obs1(), rsp(1, 1, 1, 0)); end
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'h00008000)) begin errors++; $display("FAIL word_unchanged got %h want %h", obs1(), rsp(1, 0, 0, 32'h8000)); end
        issue(1'b0, 32'(DEPTH * 4), 2'd2, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 1, 0)) begin errors++; $display("FAIL out_of_range got %h want %h", obs1(), rsp(1, 0, 1, 0)); end
        issue(1'b0, 32'h0, 2'd3, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 1, 0)) begin errors++; $display("FAIL oversized got %h want %h", obs1(), rsp(1, 0, 1, 0)); end
        issue(1'b1, 32'(DEPTH * 4 + 32'h20), 2'd2, 1'b0, 32'h12345678);
        issue(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'h00008000)) begin errors++; $display("FAIL oor_store_no_alias got %h want %h", obs1(), rsp(1, 0, 0, 32'h8000)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [3];
        v[0] = 32'h01234567; v[1] = 32'h89ABCDEF; v[2] = 32'h5A5AA5A5;
        for (int i = 0; i < 3; i++) issue(1'b1, 32'(i * 4), 2'd2, 1'b0, v[i]);
        wait_cycles(2);
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        checks++; if (obs2() !== '0) begin errors++; $display("FAIL lat2_not_early got %h want 0", obs2()); end
        issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
        checks++; if (obs2() !== rsp(1, 0, 0, v[0])) begin errors++; $display("FAIL lat2_beat0 got %h want %h", obs2(), rsp(1, 0, 0, v[0])); end
        issue(1'b0, 32'h8, 2'd2, 1'b0, 32'h0);
        checks++; if (obs2() !== rsp(1, 0, 0, v[1])) begin errors++; $display("FAIL lat2_beat1 got %h want %h", obs2(), rsp(1, 0, 0, v[1])); end
        wait_cycles(1);
        checks++; if (obs2() !== rsp(1, 0, 0, v[2])) begin errors++; $display("FAIL lat2_beat2 got %h want %h", obs2(), rsp(1, 0, 0, v[2])); end
        wait_cycles(1);
        checks++; if (obs2() !== '0) begin errors++; $display("FAIL lat2_drain got %h want 0", obs2()); end
        // stall for two edges in mid-stream, with the third load waiting on the inputs
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
        en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_size = 2'd2; req_unsigned = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (obs2() !== rsp(1, 0, 0, v[0])) begin errors++; $display("FAIL stall_hold_dut2 got %h want %h", obs2(), rsp(1, 0, 0, v[0])); end
            checks++; if (obs1() !== rsp(1, 0, 0, v[1])) begin errors++; $display("FAIL stall_hold_dut1 got %h want %h", obs1(), rsp(1, 0, 0, v[1])); end
        end
        en = 1'b1;
        step();
        idle();
        checks++; if (obs2() !== rsp(1, 0, 0, v[1])) begin errors++; $display("FAIL stall_resume1 got %h want %h", obs2(), rsp(1, 0, 0, v[1])); end
        checks++; if (obs1() !== rsp(1, 0, 0, v[2])) begin errors++; $display("FAIL stall_resume_dut1 got %h want %h", obs1(), rsp(1, 0, 0, v[2])); end
        wait_cycles(1);
        checks++; if (obs2() !== rsp(1, 0, 0, v[2])) begin errors++; $display("FAIL stall_resume2 got %h want %h", obs2(), rsp(1, 0, 0, v[2])); end
        wait_cycles(1);
        checks++; if (obs2() !== '0) begin errors++; $display("FAIL stall_drain got %h want 0", obs2()); end
    endtask

    task automatic test_flush();
        issue(1'b1, 32'h30, 2'd2, 1'b0, 32'hCAFEF00D);
        wait_cycles(2);
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
        flush = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_size = 2'd2; req_wdata = 32'h11223344;
        step();
        flush = 1'b0;
        idle();
        checks++; if (obs1() !== '0) begin errors++; $display("FAIL flush_dut1 got %h want 0", obs1()); end
        checks++; if (obs2() !== '0) begin errors++; $display("FAIL flush_dut2 got %h want 0", obs2()); end
        step();
        checks++; if (obs2() !== '0) begin errors++; $display("FAIL flush_no_late_rsp got %h want 0", obs2()); end
        wait_cycles(1);
        issue(1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 32'hCAFEF00D)) begin errors++; $display("FAIL flush_store_dropped got %h want %h", obs1(), rsp(1, 0, 0, 32'hCAFEF00D)); end
        // flush while stalled
        wait_cycles(2);
        issue(1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
        en = 1'b0; flush = 1'b1;
        step();
        en = 1'b1; flush = 1'b0;
        checks++; if (obs1() !== '0) begin errors++; $display("FAIL flush_stalled_dut1 got %h want 0", obs1()); end
        step();
        checks++; if (obs2() !== '0) begin errors++; $display("FAIL flush_stalled_dut2 got %h want 0", obs2()); end
    endtask

    task automatic test_reset_mid();
        wait_cycles(2);
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'd0; req_wdata = 32'h55;
        step();
        rst = 1'b0;
        idle();
        checks++; if (obs1() !== '0) begin errors++; $display("FAIL rst_mid_dut1 got %h want 0", obs1()); end
        checks++; if (obs2() !== '0) begin errors++; $display("FAIL rst_mid_dut2 got %h want 0", obs2()); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (obs2() !== '0 || obs1() !== '0) begin errors++; $display("FAIL rst_no_late_rsp got %h/%h want 0", obs1(), obs2()); end
        end
        issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
        checks++; if (obs1() !== rsp(1, 0, 0, 0)) begin errors++; $display("FAIL rst_store_dropped got %h want %h", obs1(), rsp(1, 0, 0, 0)); end
    endtask

    task automatic test_random();
        int sz;
        for (int n = 0; n < 800; n++) begin
            rst          = ($urandom_range(0, 59) == 0);
            flush        = ($urandom_range(0, 19) == 0);
            en           = ($urandom_range(0, 9) < 8);
            req_valid    = ($urandom_range(0, 9) < 7);
            req_we       = ($urandom_range(0, 2) == 0);
            req_unsigned = 1'($urandom_range(0, 1));
            req_wdata    = $urandom;
            sz           = $urandom_range(0, 9);
            req_size     = (sz < 3) ? 2'd0 : (sz < 6) ? 2'd1 : (sz < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 3) != 0) req_addr = 32'($urandom_range(0, 63));
            else                           req_addr = 32'($urandom_range(0, DEPTH * 4 + 15));
            if ($urandom_range(0, 3) != 0) req_addr = req_addr & ~((32'd1 << req_size) - 32'd1);
            step();
            checks++; if (obs1() !== exp_q1[$]) begin errors++; $display("FAIL random_dut1 cycle %0d got %h want %h", n, obs1(), exp_q1[$]); end
            checks++; if (obs2() !== exp_q2[$]) begin errors++; $display("FAIL random_dut2 cycle %0d got %h want %h", n, obs2(), exp_q2[$]); end
        end
        rst = 1'b0; flush = 1'b0; en = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        init_mem();
        test_word();
        test_byte_ext();
        test_errors();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
